datapath_ctrl: RTL and testbench
================================

# datapath_ctrl

Instruction sequencer for the 16-bit register-file/ALU datapath. Accepts one 16-bit instruction word per handshake, decodes it into register-file read addresses, ALU opcode and immediate selection, then steps a fixed read/execute/write-back sequence. In the write-back step it drives the one-hot register write enable. It sits between the instruction source and the regfile/ALU pair and is the only block that drives their control inputs.

## Interface
Parameters:
- `NREGS`, 16: register count; width of `reg_en`.
- `FLAGW`, 5: ALU flag width, ordered {C, L, F, Z, N}.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `instr` input 16: instruction word; sampled on accept.
- `instr_valid` input 1: the source has an instruction on `instr`.
- `instr_ready` output 1: the controller can accept an instruction.
- `alu_flags` input FLAGW: flags from the ALU, meaningful in EXEC.
- `raddr_a` output 4: regfile port A address (= rdest).
- `raddr_b` output 4: regfile port B address (= rsrc).
- `alu_opcode` output 4: ALU operation select.
- `immediate` output 8: immediate field; the datapath zero-extends it.
- `imm_sel` output 1: 1 selects the immediate for ALU operand B; 0 selects `rdataB`.
- `alu_cin` output 1: ALU carry-in.
- `reg_en` output NREGS: one-hot write enable, asserted only in WB.
- `busy` output 1: the controller is not in IDLE.
- `done` output 1: one-cycle pulse in the WB cycle.
- `psr` output FLAGW: stored processor-status flags.

## Operation
Instruction decode:
- Fields: op_hi = instr[15:12], rdest = [11:8], op_ext = [7:4], rsrc = [3:0].
- op_hi == 0 is register form:
  - `alu_opcode` = op_ext, `imm_sel` = 0.
  - op_ext == 0 is NOP: no write-back and no flag update.
- op_hi != 0 is immediate form:
  - `alu_opcode` = op_hi, `imm_sel` = 1, `immediate` = instr[7:0].
- ALU opcode CMP (0xB) updates flags but never writes a register.

State machine: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: `instr_ready` = 1. If `instr_valid`, capture `instr` into the instruction register and go to READ.
- READ: drive the addresses and selects; operands settle.
- EXEC: the ALU result is stable. Sample `alu_flags` for the flag update.
- WB: `reg_en` = 1 << rdest unless the instruction is NOP or CMP, in which case `reg_en` = 0. `done` = 1.

Output and register rules:
- Address, opcode, immediate and select outputs come from the captured instruction register. They hold constant from READ through WB, and also in IDLE.
- Reset values: state IDLE; instruction register 0; `reg_en` 0; `done` 0; `busy` 0; `psr` 0; `alu_cin` 0; `instr_ready` 1 once reset deasserts.
- If reset is asserted mid-sequence, the next edge returns the controller to IDLE with `reg_en` = 0. No partial write occurs and the in-flight instruction is dropped.
- `instr_valid` outside IDLE is ignored; `instr_ready` is 0 there.

## Timing
- Accept at edge E0. READ is cycle 1, EXEC cycle 2, WB cycle 3.
- The register write commits at the edge ending cycle 3. `instr_ready` returns in cycle 4.
- Throughput is one instruction per 4 cycles. Back-to-back `instr_valid` is accepted in cycle 4.
- All outputs are registered or decoded from state/instruction register only. There is no combinational path from `instr`/`alu_flags` to any output.
- The flag update lands at the edge ending EXEC, so `psr` is visible in WB.

## Configuration
- `DATAPATH_CTRL_PSR_EN` defined:
  - The `psr` register is loaded from `alu_flags` at the end of EXEC for every non-NOP instruction.
  - `alu_cin` = `psr`[C].
- Not defined:
  - No flag storage; `psr` is tied to 0 and `alu_cin` is tied to 0.
  - `alu_flags` is unused.

## Structure
- Shared package `datapath_pkg`:
  - State enum (IDLE, READ, EXEC, WB).
  - ALU opcode constants, including OP_CMP = 4'hB and EXT_NOP = 4'h0.
  - Flag bit indices FLAG_C..FLAG_N.
  - Instruction field position constants.
- One sub-module, `instr_decode`: combinational. Takes the instruction register and produces `alu_opcode`, `imm_sel`, `immediate`, `raddr_a`, `raddr_b`, wb_en and flag_en.
- The FSM, instruction register and PSR live in `datapath_ctrl`.

## Test plan
- Reset with `reset` = 0 for 2 cycles: all outputs at their reset values; `instr_ready` = 1 after release.
- Register-form ADD, instr = 0x0_3_5_7 (rdest 3, ext 5, rsrc 7), accepted at E0: `raddr_a` = 3, `raddr_b` = 7, `imm_sel` = 0, `alu_opcode` = 5. `reg_en` = 0x0008 and `done` = 1 in cycle 3 only.
- Immediate form, instr = 0x5_A_FF: `alu_opcode` = 5, `imm_sel` = 1, `immediate` = 0xFF. `reg_en` = 0x0400 in WB.
- CMP (0xB_2_10) and NOP (0x0_4_0_1): `reg_en` stays 0 for the whole sequence, `done` still pulses, and `busy` = 1 for 3 cycles. With PSR_EN:
  - CMP with `alu_flags` = 5'b00010 leaves `psr` = 5'b00010.
  - NOP leaves `psr` unchanged.
- Reset asserted during EXEC of a write instruction: no `reg_en` pulse; state is IDLE on the next cycle; `psr` = 0.
- `instr_valid` held high continuously for 3 instructions: accepts at cycles 0, 4 and 8. An `instr` change while `busy` does not alter the outputs.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// datapath_pkg: shared definitions for the instruction sequencer and its
// decoder. Holds the sequencer state encoding, ALU opcode constants, flag
// bit positions and instruction field positions.
//
// Instruction word layout:
//   [15:12] op_hi    0 = register form, otherwise the ALU opcode (immediate form)
//   [11:8]  rdest    destination register / port A address
//   [7:4]   op_ext   ALU opcode for register form (0 = NOP)
//   [3:0]   rsrc     source register / port B address
//   [7:0]   immediate (immediate form only)
package datapath_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } ctrlStateT;

  localparam logic [3:0] OP_REG  = 4'h0;  // op_hi value selecting register form
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'hB;  // updates flags, never writes back
  localparam logic [3:0] EXT_NOP = 4'h0;

  // Flag vector is ordered {C, L, F, Z, N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam int OP_HI_LSB  = 12;
  localparam int RDEST_LSB  = 8;
  localparam int OP_EXT_LSB = 4;
  localparam int RSRC_LSB   = 0;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 8;

  function automatic logic [3:0] field4(input logic [15:0] word, input int lsb);
    return word[lsb +: 4];
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// datapath_ctrl_if: instruction handshake plus the control bus toward the
// regfile/ALU pair.
//   slave  : the sequencer side (takes instructions and ALU flags, drives
//            every regfile/ALU control signal and status)
//   master : the environment side (instruction source and datapath)
// Signals: instr/instr_valid/instr_ready handshake, alu_flags, raddr_a,
// raddr_b, alu_opcode, immediate, imm_sel, alu_cin, reg_en, busy, done, psr.
interface datapath_ctrl_if #(
  parameter int NREGS = 16,
  parameter int FLAGW = 5
);
  logic [15:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [FLAGW-1:0] alu_flags;
  logic [3:0]       raddr_a;
  logic [3:0]       raddr_b;
  logic [3:0]       alu_opcode;
  logic [7:0]       immediate;
  logic             imm_sel;
  logic             alu_cin;
  logic [NREGS-1:0] reg_en;
  logic             busy;
  logic             done;
  logic [FLAGW-1:0] psr;

  modport slave (
    input  instr, instr_valid, alu_flags,
    output instr_ready, raddr_a, raddr_b, alu_opcode, immediate, imm_sel,
           alu_cin, reg_en, busy, done, psr
  );

  modport master (
    output instr, instr_valid, alu_flags,
    input  instr_ready, raddr_a, raddr_b, alu_opcode, immediate, imm_sel,
           alu_cin, reg_en, busy, done, psr
  );
endinterface

// File: rtl/datapath_ctrl_decode.sv
// instr_decode: purely combinational decode of the captured instruction
// register into datapath controls.
// Ports:
//   instrReg   in  16  captured instruction word
//   aluOpcode  out 4   ALU operation select
//   immSel     out 1   1 = immediate drives ALU operand B
//   immediate  out 8   immediate field (0 in register form)
//   raddrA     out 4   port A address (rdest)
//   raddrB     out 4   port B address (rsrc)
//   wbEn       out 1   instruction writes rdest in WB
//   flagEn     out 1   instruction updates the flags
module instr_decode
  import datapath_pkg::*;
(
  input  logic [15:0] instrReg,
  output logic [3:0]  aluOpcode,
  output logic        immSel,
  output logic [7:0]  immediate,
  output logic [3:0]  raddrA,
  output logic [3:0]  raddrB,
  output logic        wbEn,
  output logic        flagEn
);
  logic [3:0] opHi;
  logic [3:0] opExt;
  logic       regForm;
  logic       isNop;

  assign opHi    = field4(instrReg, OP_HI_LSB);
  assign opExt   = field4(instrReg, OP_EXT_LSB);
  assign regForm = (opHi == OP_REG);
  assign isNop   = regForm && (opExt == EXT_NOP);

  assign raddrA    = field4(instrReg, RDEST_LSB);
  assign raddrB    = field4(instrReg, RSRC_LSB);
  assign aluOpcode = regForm ? opExt : opHi;
  assign immSel    = !regForm;
  assign immediate = regForm ? 8'h00 : instrReg[IMM_LSB +: IMM_W];

  // CMP may arrive in either form; it only ever touches the flags.
  assign wbEn   = !isNop && (aluOpcode != OP_CMP);
  assign flagEn = !isNop;
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: instruction sequencer for the 16-bit regfile/ALU datapath.
// Accepts one instruction per handshake in IDLE, then walks
// READ -> EXEC -> WB -> IDLE, pulsing the one-hot register write enable
// and done in WB.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-low reset
//   bus    datapath_ctrl_if.slave (handshake, ALU flags, regfile/ALU controls)
// Parameters: NREGS (reg_en width), FLAGW (flag width, {C,L,F,Z,N}).
// Optional feature macro: DATAPATH_CTRL_PSR_EN enables the processor-status
// register and carry-in from it; without it psr and alu_cin are tied to 0.
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int FLAGW = 5
) (
  input logic            clk,
  input logic            reset,
  datapath_ctrl_if.slave bus
);
  ctrlStateT        state;
  logic [15:0]      instrReg;
  logic [NREGS-1:0] regEn;
  logic             doneReg;
  logic             busyReg;
  logic             readyReg;

  logic [3:0] aluOpcode;
  logic       immSel;
  logic [7:0] immediate;
  logic [3:0] raddrA;
  logic [3:0] raddrB;
  logic       wbEn;
  logic       flagEn;

`ifdef DATAPATH_CTRL_PSR_EN
  logic [FLAGW-1:0] psrReg;
`endif

  instr_decode uDecode (
    .instrReg (instrReg),
    .aluOpcode(aluOpcode),
    .immSel   (immSel),
    .immediate(immediate),
    .raddrA   (raddrA),
    .raddrB   (raddrB),
    .wbEn     (wbEn),
    .flagEn   (flagEn)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      instrReg <= '0;
      regEn    <= '0;
      doneReg  <= 1'b0;
      busyReg  <= 1'b0;
      readyReg <= 1'b1;
`ifdef DATAPATH_CTRL_PSR_EN
      psrReg   <= '0;
`endif
    end else begin
      case (state)
        // Accept: the instruction register is the only place instr is seen
        IDLE: begin
          if (bus.instr_valid) begin
            instrReg <= bus.instr;
            busyReg  <= 1'b1;
            readyReg <= 1'b0;
            state    <= READ;
          end
        end
        // Operands settle on the decoded addresses
        READ: state <= EXEC;
        // ALU result stable; load WB strobes and flags for the next cycle
        EXEC: begin
          regEn   <= wbEn ? (NREGS'(1) << raddrA) : '0;
          doneReg <= 1'b1;
`ifdef DATAPATH_CTRL_PSR_EN
          if (flagEn) psrReg <= bus.alu_flags;
`endif
          state   <= WB;
        end
        // Write commits at the end of this cycle
        WB: begin
          regEn    <= '0;
          doneReg  <= 1'b0;
          busyReg  <= 1'b0;
          readyReg <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready = readyReg;
  assign bus.raddr_a     = raddrA;
  assign bus.raddr_b     = raddrB;
  assign bus.alu_opcode  = aluOpcode;
  assign bus.immediate   = immediate;
  assign bus.imm_sel     = immSel;
  assign bus.reg_en      = regEn;
  assign bus.busy        = busyReg;
  assign bus.done        = doneReg;

`ifdef DATAPATH_CTRL_PSR_EN
  assign bus.psr     = psrReg;
  assign bus.alu_cin = psrReg[FLAG_C];
`else
  logic unusedFlags;
  assign unusedFlags = ^{bus.alu_flags, flagEn};
  assign bus.psr     = '0;
  assign bus.alu_cin = 1'b0;
`endif
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed-vector bench for datapath_ctrl.
module tb_datapath_ctrl;
  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;
  logic [4:0] expPsr;

`ifdef DATAPATH_CTRL_PSR_EN
  localparam bit PSR_ON = 1'b1;
`else
  localparam bit PSR_ON = 1'b0;
`endif

  datapath_ctrl_if #(.NREGS(16), .FLAGW(5)) dif ();

  datapath_ctrl #(.NREGS(16), .FLAGW(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkDecode(input string tag, input logic [3:0] expA, input logic [3:0] expB,
                             input logic [3:0] expOp, input logic expSel, input logic [7:0] expImm);
    checkVal({tag, " raddr_a"}, 32'(dif.raddr_a), 32'(expA));
    checkVal({tag, " raddr_b"}, 32'(dif.raddr_b), 32'(expB));
    checkVal({tag, " alu_opcode"}, 32'(dif.alu_opcode), 32'(expOp));
    checkVal({tag, " imm_sel"}, 32'(dif.imm_sel), 32'(expSel));
    if (expSel) checkVal({tag, " immediate"}, 32'(dif.immediate), 32'(expImm));
  endtask

  // One full accept..IDLE sequence starting in IDLE.
  task automatic doInstr(input string tag, input logic [15:0] iw, input logic [4:0] flags,
                         input logic [3:0] expA, input logic [3:0] expB, input logic [3:0] expOp,
                         input logic expSel, input logic [7:0] expImm,
                         input logic [15:0] expEn, input logic updFlags);
    checkVal({tag, " ready idle"}, 32'(dif.instr_ready), 32'd1);
    dif.instr       = iw;
    dif.instr_valid = 1'b1;
    dif.alu_flags   = flags;
    step();
    dif.instr_valid = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (cyc == 3 && PSR_ON && updFlags) expPsr = flags;
      checkDecode(tag, expA, expB, expOp, expSel, expImm);
      checkVal($sformatf("%s reg_en c%0d", tag, cyc), 32'(dif.reg_en), (cyc == 3) ? 32'(expEn) : 32'd0);
      checkVal($sformatf("%s done c%0d", tag, cyc), 32'(dif.done), (cyc == 3) ? 32'd1 : 32'd0);
      checkVal($sformatf("%s busy c%0d", tag, cyc), 32'(dif.busy), 32'd1);
      checkVal($sformatf("%s ready c%0d", tag, cyc), 32'(dif.instr_ready), 32'd0);
      checkVal($sformatf("%s psr c%0d", tag, cyc), 32'(dif.psr), 32'(expPsr));
      checkVal($sformatf("%s alu_cin c%0d", tag, cyc), 32'(dif.alu_cin), 32'(expPsr[4]));
      step();
    end
    checkVal({tag, " busy c4"}, 32'(dif.busy), 32'd0);
    checkVal({tag, " ready c4"}, 32'(dif.instr_ready), 32'd1);
    checkVal({tag, " reg_en c4"}, 32'(dif.reg_en), 32'd0);
    checkVal({tag, " done c4"}, 32'(dif.done), 32'd0);
    checkDecode({tag, " idle"}, expA, expB, expOp, expSel, expImm);
  endtask

  logic [15:0] b2b [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nChecks = 0;
    nFails  = 0;
    expPsr  = 5'b0;
    dif.instr       = 16'h0000;
    dif.instr_valid = 1'b0;
    dif.alu_flags   = 5'b0;

    // Reset held for two cycles
    reset = 1'b0;
    step();
    step();
    checkVal("rst reg_en", 32'(dif.reg_en), 32'd0);
    checkVal("rst done", 32'(dif.done), 32'd0);
    checkVal("rst busy", 32'(dif.busy), 32'd0);
    checkVal("rst psr", 32'(dif.psr), 32'd0);
    checkVal("rst alu_cin", 32'(dif.alu_cin), 32'd0);
    checkDecode("rst", 4'h0, 4'h0, 4'h0, 1'b0, 8'h00);
    reset = 1'b1;
    step();
    checkVal("rst ready after release", 32'(dif.instr_ready), 32'd1);
    checkVal("rst busy after release", 32'(dif.busy), 32'd0);

    // Register-form ADD r3 <- r3 + r7
    doInstr("add", 16'h0357, 5'b00000, 4'h3, 4'h7, 4'h5, 1'b0, 8'h00, 16'h0008, 1'b1);
    // Immediate form, opcode 5, rdest A, imm FF
    doInstr("imm", 16'h5AFF, 5'b00000, 4'hA, 4'hF, 4'h5, 1'b1, 8'hFF, 16'h0400, 1'b1);
    // CMP: flags only
    doInstr("cmp", 16'hB210, 5'b00010, 4'h2, 4'h0, 4'hB, 1'b1, 8'h10, 16'h0000, 1'b1);
    // NOP: neither write nor flag update, even with all flags presented
    doInstr("nop", 16'h0401, 5'b11111, 4'h4, 4'h1, 4'h0, 1'b0, 8'h00, 16'h0000, 1'b0);

    // Reset during EXEC of a write instruction
    dif.instr       = 16'h1C22;
    dif.instr_valid = 1'b1;
    dif.alu_flags   = 5'b10000;
    step();
    dif.instr_valid = 1'b0;
    checkVal("mrst busy read", 32'(dif.busy), 32'd1);
    step();
    reset = 1'b0;
    step();
    expPsr = 5'b0;
    checkVal("mrst reg_en", 32'(dif.reg_en), 32'd0);
    checkVal("mrst done", 32'(dif.done), 32'd0);
    checkVal("mrst busy", 32'(dif.busy), 32'd0);
    checkVal("mrst ready", 32'(dif.instr_ready), 32'd1);
    checkVal("mrst psr", 32'(dif.psr), 32'd0);
    checkVal("mrst alu_cin", 32'(dif.alu_cin), 32'd0);
    reset = 1'b1;
    step();
    checkVal("mrst reg_en after", 32'(dif.reg_en), 32'd0);
    checkVal("mrst busy after", 32'(dif.busy), 32'd0);
    checkVal("mrst done after", 32'(dif.done), 32'd0);

    // Back-to-back: valid held high, accepts at cycles 0, 4, 8;
    // instr scribbled with FFFF while busy must not disturb outputs.
    b2b[0] = 16'h1123;
    b2b[1] = 16'h2234;
    b2b[2] = 16'h3345;
    dif.alu_flags   = 5'b00000;
    dif.instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c % 4 == 0) begin
        checkVal($sformatf("b2b ready c%0d", c), 32'(dif.instr_ready), 32'd1);
        dif.instr = b2b[c / 4];
      end else begin
        checkVal($sformatf("b2b ready c%0d", c), 32'(dif.instr_ready), 32'd0);
        dif.instr = 16'hFFFF;
      end
      step();
      checkVal($sformatf("b2b raddr_a c%0d", c + 1), 32'(dif.raddr_a), 32'((c / 4) + 1));
      checkVal($sformatf("b2b alu_opcode c%0d", c + 1), 32'(dif.alu_opcode), 32'((c / 4) + 1));
      checkVal($sformatf("b2b immediate c%0d", c + 1), 32'(dif.immediate), 32'(8'h23 + 8'h11 * (c / 4)));
      checkVal($sformatf("b2b reg_en c%0d", c + 1), 32'(dif.reg_en),
               (c % 4 == 2) ? (32'd2 << (c / 4)) : 32'd0);
    end
    dif.instr_valid = 1'b0;
    checkVal("b2b ready end", 32'(dif.instr_ready), 32'd1);
    checkVal("b2b busy end", 32'(dif.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
